clk_div_prog: RTL
=================

# clk_div_prog

Runtime-programmable, multi-channel clock divider; generalises the fixed single-output divider to CHANNELS independent outputs whose half-period is reloadable over a valid/ready config port. Each channel produces a 50 % duty divided clock plus a one-cycle tick strobe, and divisor changes take effect only on a period boundary so outputs never glitch. Sits beside the baud/timebase generators, letting UART and sampling logic retune rates without reset.

## Interface
- IN_FREQ, 50000000, input clock frequency in Hz
- OUT_FREQ, 9600, reset output frequency of every channel
- CHANNELS, 4, number of independent divider channels (>=1)
- WIDTH, 16, half-period counter/divisor width
- clk  in  1  system clock; sole clock domain
- rst  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  write can be accepted
- cfg_chan  in  CH_W  target channel; CH_W = max(1, clog2(CHANNELS))
- cfg_half  in  WIDTH  new half-period in clk cycles
- en  in  CHANNELS  per-channel run enable
- new_clk  out  CHANNELS  divided clocks
- tick  out  CHANNELS  one-cycle strobe coincident with each new_clk rise
- busy  out  CHANNELS  update pending on channel

## Operation
- Per channel: cnt (WIDTH), h_act (WIDTH), h_pend (WIDTH), pend flag, new_clk, tick; all registered.
- Reset: cnt=0, h_act=DEFAULT_HALF=IN_FREQ/(2*OUT_FREQ) (integer floor), pend=0, new_clk=0, tick=0, busy=0. DEFAULT_HALF must fit WIDTH and be >=1; otherwise elaboration fails.
- Run (en=1, h_act>=1): cnt counts 0..h_act-1; at cnt==h_act-1 new_clk toggles, cnt<=0. Output period = 2*h_act cycles; h_act=1 gives clk/2.
- tick=1 exactly in the cycle new_clk first reads 1; 0 otherwise.
- Write accepted when cfg_valid & cfg_ready; cfg_ready = !pend[cfg_chan] (combinational). On accept: h_pend<=cfg_half, pend<=1. cfg_chan >= CHANNELS: ready=1, write discarded.
- Apply: when a running channel's low phase expires (rise about to happen) and pend=1: new_clk rises, h_act<=h_pend, cnt<=0, pend<=0. Next high phase uses new value; the current period completes with old value.
- Halted channel (en=0 or h_act=0): pending value applied the cycle after accept; new_clk and tick held 0, cnt held 0.
- en 1->0: synchronous clear next cycle (new_clk=0, cnt=0), regardless of phase. en 0->1: first rise after h_act cycles.
- h_act=0: channel halted, outputs 0, until a nonzero write applies.
- Simultaneous accept and boundary on the same channel: write becomes pending, applies at the following boundary.
- busy = pend.

## Timing
- Write accepted in cycle N: busy=1 from N+1; cfg_ready for that channel low from N+1 until apply.
- Apply latency: at most 2*h_act_old cycles after accept while running; 1 cycle while halted.
- Reset mid-operation: all state returns to reset values asynchronously; pending writes lost.
- No combinational path from cfg_* to new_clk/tick.

## Configuration
- CLK_DIV_SYNC_EN defined: adds input port sync (1 bit, after en). sync=1 in a cycle forces, next cycle, every channel to cnt=0, new_clk=0, tick=0, and applies any pending value immediately (pend cleared), phase-aligning all channels. sync has priority over a boundary apply in the same cycle.
- Undefined: no sync port; channels free-run independently.

## Structure
- Package clk_div_pkg: clog2 function, DEFAULT_HALF computation function, channel-index width helper.
- Sub-module clk_div_chan: one channel (counter, h_act/h_pend, pend, outputs); clk_div_prog holds config decode, cfg_ready mux, and a generate loop of CHANNELS instances.

## Test plan
- Params IN_FREQ=100, OUT_FREQ=10, CHANNELS=2, WIDTH=8, en=2'b11 after reset -> DEFAULT_HALF=5; new_clk period 10 cycles, first rise 5 cycles after en, tick once per period.
- Write ch0 cfg_half=2 mid-high-phase -> busy[0] next cycle, cfg_ready low for chan 0, current period completes at 10, then period 4; ch1 unaffected.
- Second write to ch0 while pending -> cfg_ready=0, value not taken; write to ch1 same time accepted.
- cfg_half=0 applied -> new_clk stays 0; later cfg_half=1 -> applied next cycle, period 2 after en.
- Drop en[1] while new_clk[1]=1 -> 0 next cycle; assert rst mid-period -> all outputs 0 immediately, h_act back to 5.
- With CLK_DIV_SYNC_EN, channels at halves 3 and 5 pulse sync -> both low next cycle, rises at +3 and +5 thereafter.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared helpers for the programmable clock divider: index widths and reset divisor.
package clk_div_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

    // A single channel still needs a 1-bit select so the port never collapses.
    function automatic int ch_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

    function automatic int default_half(input int in_freq, input int out_freq);
        return in_freq / (2 * out_freq);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter with a pending divisor that is
// swapped in only at a rising boundary, so the output never glitches.
module clk_div_chan #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_HALF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_half,
    output logic             new_clk,
    output logic             tick,
    output logic             busy
);
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] h_act;
    logic [WIDTH-1:0] h_pend;
    logic             pend;
    logic             running;
    logic             boundary;

    assign running  = en && (h_act != '0);
    assign boundary = (cnt == h_act - WIDTH'(1));
    assign busy     = pend;

    // Writes only land when pend is clear, so they never collide with an apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            h_act   <= WIDTH'(DEFAULT_HALF);
            h_pend  <= '0;
            pend    <= 1'b0;
            new_clk <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (wr) begin
                h_pend <= wr_half;
                pend   <= 1'b1;
            end
            if (sync || !running) begin
                cnt     <= '0;
                new_clk <= 1'b0;
                if (pend) begin
                    h_act <= h_pend;
                    pend  <= 1'b0;
                end
            end else if (boundary) begin
                cnt     <= '0;
                new_clk <= !new_clk;
                if (!new_clk) begin
                    tick <= 1'b1;
                    if (pend) begin
                        h_act <= h_pend;
                        pend  <= 1'b0;
                    end
                end
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider with a valid/ready divisor port.
// Optional CLK_DIV_SYNC_EN adds a 'sync' input that phase-aligns all channels.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int IN_FREQ  = 50000000,
    parameter int OUT_FREQ = 9600,
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [ch_width(CHANNELS)-1:0]   cfg_chan,
    input  logic [WIDTH-1:0]                cfg_half,
    input  logic [CHANNELS-1:0]             en,
`ifdef CLK_DIV_SYNC_EN
    input  logic                            sync,
`endif
    output logic [CHANNELS-1:0]             new_clk,
    output logic [CHANNELS-1:0]             tick,
    output logic [CHANNELS-1:0]             busy
);
    localparam int CH_W         = ch_width(CHANNELS);
    localparam int SLOTS        = 1 << CH_W;
    localparam int DEFAULT_HALF = default_half(IN_FREQ, OUT_FREQ);

    if (DEFAULT_HALF < 1 || longint'(DEFAULT_HALF) >= (longint'(1) << WIDTH)) begin : g_bad_half
        $error("clk_div_prog: DEFAULT_HALF %0d does not fit WIDTH %0d or is zero",
               DEFAULT_HALF, WIDTH);
    end

    logic             sync_all;
    logic [SLOTS-1:0] pend_slots;
    logic             accept;

`ifdef CLK_DIV_SYNC_EN
    assign sync_all = sync;
`else
    assign sync_all = 1'b0;
`endif

    // Unused select codes read as not-pending, so out-of-range writes are taken and dropped.
    always_comb begin
        pend_slots                 = '0;
        pend_slots[CHANNELS-1:0]   = busy;
    end

    assign cfg_ready = !pend_slots[cfg_chan];
    assign accept    = cfg_valid && cfg_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_div_chan #(
            .WIDTH        (WIDTH),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync_all),
            .wr      (accept && (cfg_chan == CH_W'(i))),
            .wr_half (cfg_half),
            .new_clk (new_clk[i]),
            .tick    (tick[i]),
            .busy    (busy[i])
        );
    end

endmodule
